// File: rtl/key_uart_streamer.sv
// Streams a latched 256-bit key to a UART transmitter as a 34-byte frame:
// header, key bytes 0..31, XOR checksum. Aborts on lock loss or per-byte timeout.
module key_uart_streamer #(
  parameter int         CLKS_PER_BIT = 87,
  parameter logic [7:0] HEADER_BYTE  = 8'hA5,
  parameter int         TIMEOUT_CLKS = 12*CLKS_PER_BIT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         unlocked_i,
  input  logic [255:0] key_i,
  input  logic         tx_done_i,
  output logic         tx_dv_o,
  output logic [7:0]   tx_byte_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  // state    | meaning
  // S_IDLE   | waiting for start_i while unlocked
  // S_LOAD   | latch key, clear index/checksum/error
  // S_SEND   | one-cycle byte strobe to uart_tx
  // S_WAIT   | wait for tx_done_i, timeout counter running
  // S_NEXT   | advance byte index
  // S_FINISH | done pulse, zeroize key and checksum
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_NEXT, S_FINISH} state_t;

  // A non-positive override falls back to the nominal 12 bit times.
  localparam int TMO_MAX = (TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS : 12*CLKS_PER_BIT;
  localparam int TW      = $clog2(TMO_MAX + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_MAX - 1);

  state_t         state_q, state_d;
  logic [255:0]   key_q, key_d;
  logic [5:0]     idx_q, idx_d;
  logic [7:0]     cks_q, cks_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           err_q, err_d;

  logic [4:0]     key_sel;
  logic [7:0]     key_byte;
  logic [7:0]     frame_byte;
  logic           is_key_idx;

  // Frame index 0 is the header, 1..32 map to key bytes 0..31, 33 is the checksum.
  assign key_sel    = 5'(idx_q - 6'd1);
  assign key_byte   = key_q[{key_sel, 3'b000} +: 8];
  assign is_key_idx = (idx_q != 6'd0) && (idx_q != 6'd33);

  always_comb begin
    frame_byte = key_byte;
    if (idx_q == 6'd0)       frame_byte = HEADER_BYTE;
    else if (idx_q == 6'd33) frame_byte = cks_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      cks_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      cks_q   <= cks_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    cks_d   = cks_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && unlocked_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        key_d   = key_i;
        idx_d   = '0;
        cks_d   = '0;
        err_d   = 1'b0;
        state_d = S_SEND;
      end
      S_SEND: begin
        tmo_d = '0;
        if (is_key_idx) cks_d = cks_q ^ key_byte;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_i) begin
          tmo_d   = '0;
          state_d = S_NEXT;
        end else if (tmo_q >= TMO_LAST) begin
          err_d   = 1'b1;
          key_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_NEXT: begin
        if (idx_q == 6'd33) begin
          idx_d   = '0;
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = S_SEND;
        end
      end
      S_FINISH: begin
        key_d   = '0;
        cks_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Losing the unlock overrides everything, including a coincident tx_done_i.
    if ((state_q != S_IDLE) && !unlocked_i) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      key_d   = '0;
      cks_d   = '0;
      idx_d   = '0;
    end
  end

  assign tx_dv_o   = (state_q == S_SEND) && unlocked_i;
  assign tx_byte_o = ((state_q == S_SEND) || (state_q == S_WAIT)) ? frame_byte : 8'h00;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_FINISH) && unlocked_i;
  assign err_o     = err_q;

endmodule

// File: tb/tb_key_uart_streamer.sv
// Directed bench for key_uart_streamer with a simple acking uart_tx model.
module tb_key_uart_streamer;

  localparam int CPB = 4;
  localparam int TMO = 20;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         unlocked_i;
  logic [255:0] key_i;
  logic         tx_done_i;
  logic         tx_dv_o;
  logic [7:0]   tx_byte_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  int done_cnt = 0;
  int ack_cnt  = 0;
  int hold_at  = 0;

  key_uart_streamer #(
    .CLKS_PER_BIT(CPB),
    .HEADER_BYTE (8'hA5),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .unlocked_i(unlocked_i),
    .key_i     (key_i),
    .tx_done_i (tx_done_i),
    .tx_dv_o   (tx_dv_o),
    .tx_byte_o (tx_byte_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    forever begin
      @(posedge clk_i); #1;
      if (tx_dv_o) rx_q.push_back(tx_byte_o);
      if (done_o) done_cnt++;
    end
  end

  // uart_tx stand-in: acks each strobe 3 cycles later unless told to withhold.
  initial begin
    tx_done_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (tx_dv_o) begin
        ack_cnt++;
        if (ack_cnt != hold_at) begin
          repeat (3) @(posedge clk_i);
          #1 tx_done_i = 1'b1;
          @(posedge clk_i);
          #1 tx_done_i = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic start_pulse();
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    int n = 0;
    while (busy_o && n < budget) begin
      @(posedge clk_i); #1;
      n++;
    end
    timed_out = busy_o;
  endtask

  task automatic wait_strobes(input int count, output bit timed_out);
    int seen = 0;
    int n = 0;
    while (seen < count && n < 2000) begin
      @(posedge clk_i); #1;
      n++;
      if (tx_dv_o) seen++;
    end
    timed_out = (seen < count);
  endtask

  task automatic prep(input int hold);
    repeat (12) @(posedge clk_i);
    #1;
    rx_q.delete();
    done_cnt = 0;
    ack_cnt  = 0;
    hold_at  = hold;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0; unlocked_i = 1'b0; key_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if ({tx_dv_o, tx_byte_o, busy_o, done_o, err_o} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 000", {tx_dv_o, tx_byte_o, busy_o, done_o, err_o});
    end
    n_checks++;
    if (dut.key_q !== 256'h0) begin n_fail++; $display("FAIL reset_key: got nonzero key register"); end
    @(negedge clk_i) rst_i = 1'b1;
    unlocked_i = 1'b1;
  endtask

  task automatic test_full_frame();
    logic [7:0] exp_b[34];
    bit to;
    prep(0);
    for (int n = 0; n < 32; n++) key_i[8*n +: 8] = 8'(n + 1);
    exp_b[0] = 8'hA5;
    for (int n = 0; n < 32; n++) exp_b[n+1] = 8'(n + 1);
    exp_b[33] = 8'h20;
    @(posedge clk_i); #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    n_checks++;
    if (tx_dv_o !== 1'b0) begin n_fail++; $display("FAIL latency_early: tx_dv_o=%b expected 0", tx_dv_o); end
    @(posedge clk_i); #1;
    n_checks++;
    if (tx_dv_o !== 1'b1 || tx_byte_o !== 8'hA5) begin
      n_fail++;
      $display("FAIL latency_first: tx_dv_o=%b byte=%h expected 1/a5", tx_dv_o, tx_byte_o);
    end
    wait_idle(1000, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL full_frame_timeout: busy_o=%b expected 0", busy_o); end
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if (rx_q.size() != 34) begin
      n_fail++;
      $display("FAIL full_frame_len: got %0d expected 34", rx_q.size());
    end else begin
      for (int i = 0; i < 34; i++) begin
        n_checks++;
        if (rx_q[i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL full_frame_byte%0d: got %h expected %h", i, rx_q[i], exp_b[i]);
        end
      end
    end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL full_frame_done: got %0d expected 1", done_cnt); end
    n_checks++;
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL full_frame_err: got %b expected 0", err_o); end
    n_checks++;
    if (dut.key_q !== 256'h0) begin n_fail++; $display("FAIL full_frame_zeroize: key register not cleared"); end
  endtask

  task automatic test_locked();
    int busy_seen = 0;
    prep(0);
    unlocked_i = 1'b0;
    start_pulse();
    repeat (20) begin
      @(posedge clk_i); #1;
      if (busy_o) busy_seen++;
    end
    n_checks++;
    if (busy_seen != 0) begin n_fail++; $display("FAIL locked_busy: busy cycles %0d expected 0", busy_seen); end
    n_checks++;
    if (rx_q.size() != 0) begin n_fail++; $display("FAIL locked_strobes: got %0d expected 0", rx_q.size()); end
    unlocked_i = 1'b1;
  endtask

  task automatic test_timeout();
    bit to;
    int n = 0;
    prep(6);
    start_pulse();
    wait_strobes(6, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL timeout_reach: strobe 6 not seen"); end
    while (!err_o && n < TMO + 10) begin
      @(posedge clk_i); #1;
      n++;
    end
    n_checks++;
    if (n != TMO + 1) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected %0d", n, TMO + 1); end
    n_checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_state: busy=%b err=%b expected 0/1", busy_o, err_o);
    end
    n_checks++;
    if (dut.key_q !== 256'h0) begin n_fail++; $display("FAIL timeout_zeroize: key register not cleared"); end
    repeat (5) @(posedge clk_i);
    #1;
    n_checks++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL timeout_done: got %0d expected 0", done_cnt); end
  endtask

  task automatic test_abort();
    bit to;
    prep(0);
    start_pulse();
    wait_strobes(10, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL abort_reach: strobe 10 not seen"); end
    @(posedge clk_i); #1 unlocked_i = 1'b0;
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: got %b expected 1", busy_o); end
    @(posedge clk_i); #1;
    n_checks++;
    if (busy_o !== 1'b0 || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b err=%b expected 0/1", busy_o, err_o);
    end
    n_checks++;
    if (dut.key_q !== 256'h0) begin n_fail++; $display("FAIL abort_zeroize: key register not cleared"); end
    unlocked_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    n_checks++;
    if (rx_q.size() != 10 || done_cnt != 0) begin
      n_fail++;
      $display("FAIL abort_quiet: strobes %0d done %0d expected 10/0", rx_q.size(), done_cnt);
    end
    n_checks++;
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL abort_sticky: err=%b expected 1", err_o); end
  endtask

  task automatic test_retrigger();
    logic [7:0] exp_b[34];
    bit to;
    prep(0);
    for (int n = 0; n < 32; n++) key_i[8*n +: 8] = 8'hF0 ^ 8'(n);
    exp_b[0] = 8'hA5;
    for (int n = 0; n < 32; n++) exp_b[n+1] = 8'hF0 ^ 8'(n);
    exp_b[33] = 8'h00;
    start_pulse();
    @(posedge clk_i); #1;
    key_i = {32{8'h55}};
    repeat (3) begin
      repeat (5) @(posedge clk_i);
      #1 start_i = 1'b1;
      @(posedge clk_i); #1 start_i = 1'b0;
    end
    wait_idle(1000, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL retrigger_timeout: busy_o stuck"); end
    repeat (30) @(posedge clk_i);
    #1;
    n_checks++;
    if (rx_q.size() != 34) begin
      n_fail++;
      $display("FAIL retrigger_len: got %0d expected 34", rx_q.size());
    end else begin
      for (int i = 0; i < 34; i++) begin
        n_checks++;
        if (rx_q[i] !== exp_b[i]) begin
          n_fail++;
          $display("FAIL retrigger_byte%0d: got %h expected %h", i, rx_q[i], exp_b[i]);
        end
      end
    end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL retrigger_done: got %0d expected 1", done_cnt); end
    n_checks++;
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL retrigger_err_cleared: got %b expected 0", err_o); end
  endtask

  task automatic test_reset_mid_frame();
    bit to;
    prep(0);
    for (int n = 0; n < 32; n++) key_i[8*n +: 8] = 8'(n + 1);
    start_pulse();
    wait_strobes(20, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL rst_mid_reach: strobe 20 not seen"); end
    @(posedge clk_i); #3 rst_i = 1'b0;
    #1;
    n_checks++;
    if ({tx_dv_o, tx_byte_o, busy_o, done_o, err_o} !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_mid_async: got %h expected 000", {tx_dv_o, tx_byte_o, busy_o, done_o, err_o});
    end
    @(negedge clk_i) rst_i = 1'b1;
    prep(0);
    repeat (20) @(posedge clk_i);
    #1;
    n_checks++;
    if (rx_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_silent: got %0d strobes expected 0", rx_q.size()); end
    start_pulse();
    wait_idle(1000, to);
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if (to || rx_q.size() != 34) begin
      n_fail++;
      $display("FAIL rst_mid_refrm_len: got %0d expected 34", rx_q.size());
    end else begin
      n_checks++;
      if (rx_q[0] !== 8'hA5 || rx_q[33] !== 8'h20) begin
        n_fail++;
        $display("FAIL rst_mid_refrm_bytes: first %h last %h expected a5/20", rx_q[0], rx_q[33]);
      end
    end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL rst_mid_done: got %0d expected 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_locked();
    test_timeout();
    test_abort();
    test_retrigger();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_uart_streamer.md
KEY_UART_STREAMER -- requirements
Module: key_uart_streamer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87; UART bit period in clk_i cycles, passed unchanged to the downstream uart_tx.
REQ-002 SHALL have parameter HEADER_BYTE, default 8'hA5; frame-start marker byte.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 12*CLKS_PER_BIT; maximum wait per byte for tx_done_i.
REQ-004 SHALL have port clk_i, input, 1 bit: single system clock, all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start_i, input, 1 bit: request to transmit the key, from the PIN stage write-enable.
REQ-007 SHALL have port unlocked_i, input, 1 bit: PIN accepted; a transfer is permitted only while this is high.
REQ-008 SHALL have port key_i, input, 256 bits: decrypted key from the AES stage.
REQ-009 SHALL have port tx_done_i, input, 1 bit: one-cycle done pulse from uart_tx.
REQ-010 SHALL have port tx_dv_o, output, 1 bit: one-cycle byte-valid strobe to uart_tx.
REQ-011 SHALL have port tx_byte_o, output, 8 bits: byte presented to uart_tx.
REQ-012 SHALL have port busy_o, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port done_o, output, 1 bit: one-cycle pulse on a complete frame.
REQ-014 SHALL have port err_o, output, 1 bit: sticky error flag (timeout or abort).

Function
REQ-015 SHALL implement states IDLE, LOAD, SEND, WAIT, NEXT, FINISH.
REQ-016 SHALL send each frame as 34 bytes in this order: HEADER_BYTE; key bytes 0..31, where byte n = key_i[8n+7:8n]; then the checksum.
REQ-017 SHALL compute the checksum as the XOR of the 32 key bytes only, accumulated as each key byte is issued.
REQ-018 SHALL, in IDLE, move to LOAD when start_i=1 and unlocked_i=1; with unlocked_i=0, start_i SHALL be ignored and the state stays IDLE.
REQ-019 SHALL, in LOAD (one cycle), latch key_i into an internal register, set the byte index to 0, clear the checksum and clear err_o, then go to SEND.
REQ-020 SHALL, in SEND (one cycle), drive tx_dv_o=1 with tx_byte_o equal to the current frame byte, then go to WAIT.
REQ-021 SHALL, in WAIT, hold tx_byte_o stable and keep tx_dv_o=0; on tx_done_i=1 it SHALL clear the timeout counter and go to NEXT.
REQ-022 SHALL, in NEXT, increment the index; if the index was 33, go to FINISH, otherwise go to SEND.
REQ-023 SHALL, in FINISH (one cycle), pulse done_o=1, zeroize the key register and checksum, then go to IDLE.
REQ-024 SHALL give a latency of 2 cycles from start_i sampled high in IDLE to the first tx_dv_o.
REQ-025 SHALL have exactly 3 cycles of module overhead per byte, plus the uart_tx time.
REQ-026 SHALL count clk_i cycles in WAIT; if the count reaches TIMEOUT_CLKS with no tx_done_i, it SHALL set err_o=1, zeroize the key register and go to IDLE without a done_o pulse.
REQ-027 SHALL, whenever unlocked_i=0 in any non-IDLE state, abort the transfer, set err_o=1, zeroize the key register and go to IDLE on the next edge.
REQ-028 SHALL ignore start_i while busy_o=1; key_i changes after LOAD SHALL NOT affect the frame in progress.
REQ-029 SHALL ignore tx_done_i in any state other than WAIT.
REQ-030 SHALL give abort (REQ-027) priority if tx_done_i and unlocked_i falling occur in the same cycle.
REQ-031 SHALL let the timeout counter saturate and never wrap; the index SHALL be 6 bits wide and SHALL never exceed 33.
REQ-032 SHALL hold err_o until the next LOAD or reset.

Reset
REQ-033 SHALL, on rst_i=0, immediately and asynchronously enter IDLE and clear to 0: tx_dv_o, tx_byte_o, busy_o, done_o, err_o, the index, the checksum, the timeout counter and the key register.
REQ-034 SHALL, if reset occurs mid-frame, send no further tx_dv_o after release until a new valid start_i.

Verification
REQ-035 Full frame: key_i = bytes 0x01..0x20 (byte n = n+1), unlocked_i=1, start_i pulse, uart_tx model acking -> 34 strobes A5,01,...,20,20 (checksum 0x20); one done_o pulse; err_o=0.
REQ-036 Locked: unlocked_i=0, start_i pulse -> busy_o stays 0 and no tx_dv_o.
REQ-037 Timeout: withhold tx_done_i after byte 5 -> err_o=1 exactly TIMEOUT_CLKS cycles after entering WAIT; IDLE; no done_o.
REQ-038 Abort: drop unlocked_i during byte 10 -> next cycle busy_o=0, err_o=1, internal key register = 0.
REQ-039 Reset mid-frame: rst_i low during byte 20 -> all outputs 0 asynchronously; a new start after release yields a full 34-byte frame with the header first.
REQ-040 Re-trigger: start_i pulses while busy and key_i changed after LOAD -> exactly one frame, carrying the originally latched key.
